// File: rtl/tron_vga_scan.sv
// Framebuffer-to-VGA scanner: 640x480@60 timing, 2x2 pixel doubling, 3-bit to 12-bit colour.
// Latency: counter position to pins is 2+RD_LAT pix_en steps; frame_start is registered directly off the counters.
module tron_vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_WIDTH = 320,
    parameter int RD_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_en,
    output logic [18:0] ram_address,
    input  logic [2:0]  ram_read_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIPE    = 1 + RD_LAT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic [18:0]     r_line_base;
    logic [18:0]     r_ram_address;
    logic [PIPE-1:0] r_act_d;
    logic [PIPE-1:0] r_hs_d;
    logic [PIPE-1:0] r_vs_d;
    logic            r_hsync;
    logic            r_vsync;
    logic [3:0]      r_r;
    logic [3:0]      r_g;
    logic [3:0]      r_b;
    logic            r_blank_n;
    logic            r_frame_start;

    logic            w_h_last;
    logic            w_v_last;
    logic            w_active;
    logic            w_hs;
    logic            w_vs;
    logic            w_line_end;
    logic [18:0]     w_pix_addr;

    assign w_h_last   = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last   = (r_v_cnt == VW'(V_TOTAL - 1));
    assign w_active   = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign w_hs       = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) && (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs       = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) && (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    // Row base advances after odd lines only, so each framebuffer row is scanned twice.
    assign w_line_end = (r_h_cnt == HW'(H_ACTIVE - 1)) && (r_v_cnt < VW'(V_ACTIVE)) && r_v_cnt[0];
    assign w_pix_addr = r_line_base + 19'(r_h_cnt >> 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_line_base   <= '0;
            r_ram_address <= '0;
            r_act_d       <= '0;
            r_hs_d        <= '0;
            r_vs_d        <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pix_en && w_h_last && w_v_last;
            if (pix_en) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end

                if (w_h_last && w_v_last)
                    r_line_base <= '0;
                else if (w_line_end)
                    r_line_base <= r_line_base + 19'(FB_WIDTH);

                r_ram_address <= w_active ? w_pix_addr : '0;

                r_act_d <= {r_act_d[PIPE-2:0], w_active};
                r_hs_d  <= {r_hs_d[PIPE-2:0], w_hs};
                r_vs_d  <= {r_vs_d[PIPE-2:0], w_vs};

                // RAM data for this position arrives with the last delay stage.
                r_hsync   <= ~r_hs_d[PIPE-1];
                r_vsync   <= ~r_vs_d[PIPE-1];
                r_blank_n <= r_act_d[PIPE-1];
                r_r       <= {4{ram_read_data[2] & r_act_d[PIPE-1]}};
                r_g       <= {4{ram_read_data[1] & r_act_d[PIPE-1]}};
                r_b       <= {4{ram_read_data[0] & r_act_d[PIPE-1]}};
            end
        end
    end

    assign ram_address = r_ram_address;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign vga_blank_n = r_blank_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_tron_vga_scan.sv
// Bench for tron_vga_scan on a shrunken raster; expected pins are computed from the pix_en step count since reset.
module tb_tron_vga_scan;

    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
    localparam int FBW = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int F  = HT * VT;
    localparam int LAT = 3;
    localparam int MEMSZ = FBW * (VA / 2);
    localparam int FINAL = MEMSZ - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic [18:0] ram_address;
    logic [2:0]  ram_read_data;
    logic        vga_hsync, vga_vsync, vga_blank_n, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;

    bit [2:0] mem [0:MEMSZ-1];
    int       s;
    bit       last_en;
    int       vectors = 0;
    int       miscompares = 0;

    tron_vga_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_WIDTH(FBW), .RD_LAT(1)
    ) dut (
        .clock(clock), .reset(reset), .pix_en(pix_en),
        .ram_address(ram_address), .ram_read_data(ram_read_data),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_blank_n(vga_blank_n), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    // Framebuffer with a one-step registered read port.
    always @(posedge clock) begin
        if (pix_en)
            ram_read_data <= (int'(ram_address) < MEMSZ) ? mem[int'(ram_address)] : 3'b000;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            s       <= 0;
            last_en <= 1'b0;
        end else begin
            if (pix_en) s <= s + 1;
            last_en <= pix_en;
        end
    end

    task automatic cmp(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s step=%0d got %0d expected %0d", tag, s, got, exp);
        end
    endtask

    task automatic check();
        int h, v, n, e_addr, e_hs, e_vs, e_bn, e_r, e_g, e_b, e_fs;
        bit [2:0] px;
        e_addr = 0; e_hs = 1; e_vs = 1; e_bn = 0; e_r = 0; e_g = 0; e_b = 0; e_fs = 0;
        if (!reset) begin
            if (s >= 1) begin
                n = (s - 1) % F;
                h = n % HT;
                v = n / HT;
                if (h < HA && v < VA) e_addr = (v / 2) * FBW + h / 2;
                if (last_en && n == F - 1) e_fs = 1;
                if (h == HA - 1 && v == VA - 1) cmp("final_addr", int'(ram_address), FINAL);
            end
            if (s >= LAT) begin
                n = (s - LAT) % F;
                h = n % HT;
                v = n / HT;
                e_hs = (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
                e_vs = (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
                if (h < HA && v < VA) begin
                    e_bn = 1;
                    px = mem[(v / 2) * FBW + h / 2];
                    e_r = px[2] ? 15 : 0;
                    e_g = px[1] ? 15 : 0;
                    e_b = px[0] ? 15 : 0;
                end
            end
        end
        cmp("ram_address", int'(ram_address), e_addr);
        cmp("hsync", int'(vga_hsync), e_hs);
        cmp("vsync", int'(vga_vsync), e_vs);
        cmp("blank_n", int'(vga_blank_n), e_bn);
        cmp("red", int'(vga_r), e_r);
        cmp("green", int'(vga_g), e_g);
        cmp("blue", int'(vga_b), e_b);
        cmp("frame_start", int'(frame_start), e_fs);
    endtask

    task automatic step(input bit en);
        pix_en = en;
        @(negedge clock);
        check();
    endtask

    initial begin
        int k;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 3'($urandom_range(0, 7));
        mem[0] = 3'b100;
        mem[1] = 3'b011;

        // Reset held: pins at reset values even with pix_en high.
        repeat (3) step(1'b1);
        reset = 1'b0;

        // Continuous pixel enable over two full frames plus margin.
        repeat (2 * F + 10) step(1'b1);

        // Random enable pattern.
        repeat (1000) step(1'($urandom_range(0, 1)));

        // Half-rate enable: every held cycle must leave the pins unchanged.
        for (int i = 0; i < 900; i++) step(i % 2 == 0);

        // Run to mid-frame, then reset for three clocks and swap in an all-white framebuffer.
        k = 0;
        while ((s % F) != 200 && k < 2 * F) begin
            step(1'b1);
            k++;
        end
        cmp("reach_midframe", int'((s % F) == 200), 1);
        reset = 1'b1;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 3'b111;
        repeat (3) step(1'b1);
        reset = 1'b0;

        // First hsync fall after reset, measured in pix_en steps.
        k = 0;
        while (vga_hsync !== 1'b0 && k < 100) begin
            step(1'b1);
            k++;
        end
        cmp("hsync_first_fall", k, HA + HF + LAT);

        // No frame_start until one full frame after reset, then the pulse.
        while (s < F + 20) step(1'b1);
        repeat (500) step(1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
